// File: rtl/regfile_clk_en_rp.sv
// Clock-enabled register bank: one write port and two registered read ports.
// Supports an optional hardwired-zero R0, write-to-read bypass and a synchronous clear.
module regfile_clk_en_rp #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned AW      = 3,
   parameter int unsigned ZERO_R0 = 1,
   parameter int unsigned BYPASS  = 1
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             clk_en,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             wr_en_c;

   // An address is backed by storage only if in range and not the hardwired zero.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (32'(a) < DEPTH) && !((ZERO_R0 != 0) && (a == '0));
   endfunction

   function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] ra);
      logic [WIDTH-1:0] val;
      val = '0;
      if (addr_live(ra)) begin
         if ((BYPASS != 0) && wr_en_c && (waddr == ra)) begin
            val = wdata;
         end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (ra == AW'(i)) val = mem_q[i];
            end
         end
      end
      return val;
   endfunction

   assign wr_en_c = we && addr_live(waddr);

   always_comb begin
      mem_d     = mem_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      if (clk_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en_c && (waddr == AW'(i))) mem_d[i] = wdata;
         end
         rdata_a_d = read_word(raddr_a);
         rdata_b_d = read_word(raddr_b);
      end
   end

   // CLR wins over clk_en, so a write in a clearing cycle is dropped.
   always_ff @(posedge clk) begin
      if (CLR) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         mem_q     <= mem_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;

endmodule

// File: doc/regfile_clk_en_rp.md
Name: regfile_clk_en_rp

Overview:
- Parametrised register bank for the multicycle RISC datapath, generalising the single 16-bit clock-enabled clearable register to DEPTH words of WIDTH bits.
- One synchronous write port and two registered read ports (A, B), with an optional hardwired-zero R0 and optional write-to-read bypass.
- Sits between instruction decode and the ALU operand latches.
- Read data is held stable across multicycle phases whenever clk_en is low.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 8: number of registers; need not be a power of two.
- AW, 3: address width; must satisfy 2**AW >= DEPTH.
- ZERO_R0, 1: 1 = register 0 always reads 0 and ignores writes; 0 = R0 is a normal register.
- BYPASS, 1: 1 = a same-cycle write to a read address is forwarded to the read output; 0 = the read returns the old contents.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset: synchronous and active-high; clears all storage and both outputs.
- clk_en  in  1  global enable; when 0, no storage or output changes.
- we  in  1  write enable, qualified by clk_en.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- raddr_b  in  AW  read address, port B.
- rdata_a  out  WIDTH  registered read data, port A.
- rdata_b  out  WIDTH  registered read data, port B.

Behaviour:
- Reset and priority, evaluated at each rising edge in this order: CLR, then clk_en, then we.
- CLR=1: every register and both rdata outputs go to 0 at that edge, regardless of clk_en, we or addresses. A pending write in that cycle is discarded.
- Reset value of rdata_a and rdata_b: 0.
- CLR=0, clk_en=0: all registers and both outputs hold. we and the addresses are ignored.
- Write (CLR=0, clk_en=1, we=1):
  - mem[waddr] <= wdata at the edge.
  - Ignored if waddr >= DEPTH.
  - Ignored if waddr == 0 and ZERO_R0 == 1.
- Read (CLR=0, clk_en=1): each port samples its address at the edge. Data appears on rdata_x one cycle later (latency 1) and holds until the next enabled edge.
- Read value rules, in priority order for each port:
  - raddr_x >= DEPTH: 0.
  - raddr_x == 0 and ZERO_R0 == 1: 0.
  - BYPASS == 1, and an effective write (after the ignore rules) hits raddr_x in the same cycle: wdata.
  - Otherwise: mem[raddr_x] before this edge's write.
- Both ports may read the same address; each output then carries the same value.
- Reading and writing different addresses in the same cycle has no interaction.
- CLR and clk_en are sampled only at the rising edge; no asynchronous paths anywhere.
- Holding CLR high for multiple cycles keeps everything at 0. Storage stays 0 after CLR deasserts until written.
- X on wdata with we=0 must not propagate into storage.

Test Plan:
1. Reset and write: hold CLR=1 for 2 cycles -> rdata_a = rdata_b = 0. Release CLR, set clk_en=1, write R3=16'h1111, then read A=3, B=3 -> both read 16'h1111 one cycle after the address edge.
2. clk_en hold: with R5=16'h2222 and rdata_a showing 16'h2222, drop clk_en and present we=1, waddr=5, wdata=16'hdddd, raddr_a=3 for 3 cycles -> rdata_a stays 16'h2222 and R5 is unchanged. Restore clk_en and read 5 -> 16'h2222.
3. R0 and out-of-range: with ZERO_R0=1, write R0=16'hffff and read R0 -> 0. With DEPTH=6, AW=3, write addr 7 = 16'h4444 and read 7 -> 0; R1..R5 unchanged.
4. Bypass: with BYPASS=1, write R2=16'h8888 while raddr_a=2 in the same cycle, R2 previously 16'h1111 -> rdata_a = 16'h8888 next cycle. With BYPASS=0, the same stimulus gives 16'h1111 first, then 16'h8888 on the following read.
5. Reset mid-operation: assert CLR in the same cycle as a write of R4=16'hcccc -> R4 reads 0 afterwards and both outputs are 0 the next cycle.
6. Width/depth sweep: with WIDTH=32, DEPTH=16, write each Rn = {16'hA5A5, n} and read back on both ports in reversed order -> every value matches, and R0 reads 0.
